// File: rtl/mem_lsu.sv
// ---------------------------------------------------------------------------
// mem_lsu : RV32E load/store unit for a big-endian, byte-addressable data RAM
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_lsu #(
  parameter int unsigned MEM_BYTES = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  localparam logic [32:0] c_mem_limit = 33'(MEM_BYTES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WSETUP = 3'd2,
    WPULSE = 3'd3,
    RESP   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_write_q, mem_write_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [2:0]  w_size;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_oor;
  logic        w_req_err;
  logic [31:0] w_load_ext;

  // Request checks; 33-bit sum so wrap past 2^32 reads as out of range.
  always_comb begin
    w_size = 3'd0;
    case (req_funct3[1:0])
      2'b00:   w_size = 3'd1;
      2'b01:   w_size = 3'd2;
      2'b10:   w_size = 3'd4;
      default: w_size = 3'd0;
    endcase
    w_illegal  = (req_funct3[1:0] == 2'b11) ||
                 (req_we ? req_funct3[2] : (req_funct3[2] & req_funct3[1]));
    w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    w_oor      = ({1'b0, req_addr} + {30'd0, w_size}) > c_mem_limit;
    w_req_err  = w_illegal | w_misalign | w_oor;
  end

  // Addressed byte always arrives in [31:24].
  always_comb begin
    case (f3_q)
      3'b000:  w_load_ext = {{24{mem_rdata[31]}}, mem_rdata[31:24]};
      3'b001:  w_load_ext = {{16{mem_rdata[31]}}, mem_rdata[31:16]};
      3'b100:  w_load_ext = {24'd0, mem_rdata[31:24]};
      3'b101:  w_load_ext = {16'd0, mem_rdata[31:16]};
      default: w_load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    f3_d         = f3_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_write_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'd0;
    resp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          f3_d    = req_funct3;
          we_d    = req_we;
          wdata_d = req_wdata[15:0];
          if (w_req_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            mem_addr_d = req_addr;
            if (req_we && (req_funct3 == 3'b010)) begin
              state_d     = WSETUP;
              mem_wdata_d = req_wdata;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD: begin
        if (we_q) begin
          state_d     = WSETUP;
          mem_wdata_d = f3_q[0] ? {wdata_q[15:0], mem_rdata[15:0]}
                                : {wdata_q[7:0], mem_rdata[23:0]};
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = w_load_ext;
        end
      end
      WSETUP: begin
        state_d     = WPULSE;
        mem_write_d = 1'b1;
      end
      WPULSE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      f3_q         <= 3'd0;
      we_q         <= 1'b0;
      wdata_q      <= 16'd0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_write_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      f3_q         <= f3_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_write_q  <= mem_write_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_write  = mem_write_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
// ---------------------------------------------------------------------------
// tb_mem_lsu : directed table, corner sequences and random traffic vs a byte model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_bad = 0;

  bit [7:0] ram     [512];
  bit [7:0] ref_mem [512];
  int       n_wr  = 0;
  int       cyc   = 0;
  int       n_acc = 0;
  logic     acc_n = 1'b0;

  mem_lsu #(.MEM_BYTES(512)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM: combinational big-endian read, write on the rising edge of the strobe.
  always_comb begin
    mem_rdata = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if ({32'd0, mem_addr} + 64'(i) < 64'd512)
        mem_rdata[31-8*i -: 8] = ram[mem_addr + 32'(i)];
    end
  end

  always @(posedge mem_write) begin
    n_wr <= n_wr + 1;
    for (int i = 0; i < 4; i++) begin
      if ({32'd0, mem_addr} + 64'(i) < 64'd512)
        ram[mem_addr + 32'(i)] <= mem_wdata[31-8*i -: 8];
    end
  end

  always @(negedge clk) acc_n <= req_valid && req_ready;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (acc_n) n_acc <= n_acc + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // Reference: access size 1<<funct3[1:0], aligned, fully inside [0,512).
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rd,
                       output logic er, output int lat, output int nw);
    int unsigned    size;
    bit             legal;
    longint unsigned acc;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 32'd1 << f3[1:0];
    rd = 32'd0; er = 1'b0; nw = 0; lat = 1;
    if (!legal || (addr % size) != 0 || (longint'(addr) + longint'(size)) > 512) begin
      er = 1'b1;
      return;
    end
    if (!we) begin
      acc = 0;
      for (int i = 0; i < int'(size); i++) acc = (acc << 8) | ref_mem[addr + 32'(i)];
      if ((f3 == 3'd0 || f3 == 3'd1) && acc[8*size-1])
        acc = acc | ~((64'd1 << (8*size)) - 64'd1);
      rd  = acc[31:0];
      lat = 2;
    end else begin
      for (int i = 0; i < int'(size); i++)
        ref_mem[addr + 32'(i)] = 8'(wdata >> (8*(int'(size)-1-i)));
      lat = (size == 4) ? 3 : 4;
      nw  = 1;
    end
  endtask

  // Starts just after a rising edge; returns just after a rising edge.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic er,
                        output int lat, output int nw, output int wat, output logic post);
    bit ok;
    rd = 32'd0; er = 1'b0; lat = 0; nw = 0; wat = 0; post = 1'b0; ok = 1'b0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      req_valid = 1'b0;
      check32("ready_wait", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (mem_write) begin nw++; wat = k; end
      if (resp_valid) begin lat = k; rd = resp_rdata; er = resp_err; break; end
    end
    @(posedge clk); #1;
    post = !resp_valid && (resp_rdata == 32'd0) && !resp_err;
  endtask

  task automatic run_one(input string nm, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit use_tbl,
                         input logic [31:0] t_rd, input logic t_er, input int t_lat, input int t_nw);
    logic [31:0] m_rd, g_rd;
    logic        m_er, g_er, post;
    int          m_lat, m_nw, g_lat, g_nw, g_wat;
    model(we, f3, addr, wdata, m_rd, m_er, m_lat, m_nw);
    if (use_tbl) begin m_rd = t_rd; m_er = t_er; m_lat = t_lat; m_nw = t_nw; end
    do_req(we, f3, addr, wdata, g_rd, g_er, g_lat, g_nw, g_wat, post);
    check32({nm, ".rdata"}, g_rd, m_rd);
    check32({nm, ".err"}, {31'd0, g_er}, {31'd0, m_er});
    check32({nm, ".latency"}, 32'(g_lat), 32'(m_lat));
    check32({nm, ".writes"}, 32'(g_nw), 32'(m_nw));
    if (m_nw == 1) check32({nm, ".wcycle"}, 32'(g_wat), 32'(m_lat - 1));
    check32({nm, ".cleared"}, {31'd0, post}, 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          nw;
  } vec_t;

  initial begin
    vec_t        tbl [20];
    logic [31:0] rd;
    logic        er, post, seen;
    int          lat, nw, wat, w0, base, t0, t1, p1, p2, nbytes;
    logic [31:0] r1, r2, e1, e2;
    logic        dummy_er;
    int          dummy_lat, dummy_nw;

    tbl[0]  = '{1'b1, 3'b010, 32'd8,   32'hDEADBEEF, 32'h00000000, 1'b0, 3, 1};
    tbl[1]  = '{1'b0, 3'b000, 32'd8,   32'h0,        32'hFFFFFFDE, 1'b0, 2, 0};
    tbl[2]  = '{1'b0, 3'b100, 32'd8,   32'h0,        32'h000000DE, 1'b0, 2, 0};
    tbl[3]  = '{1'b0, 3'b001, 32'd10,  32'h0,        32'hFFFFBEEF, 1'b0, 2, 0};
    tbl[4]  = '{1'b1, 3'b000, 32'd9,   32'h00000012, 32'h00000000, 1'b0, 4, 1};
    tbl[5]  = '{1'b0, 3'b010, 32'd8,   32'h0,        32'hDE12BEEF, 1'b0, 2, 0};
    tbl[6]  = '{1'b0, 3'b101, 32'd8,   32'h0,        32'h0000DE12, 1'b0, 2, 0};
    tbl[7]  = '{1'b0, 3'b001, 32'd3,   32'h0,        32'h00000000, 1'b1, 1, 0};
    tbl[8]  = '{1'b1, 3'b010, 32'd6,   32'h12345678, 32'h00000000, 1'b1, 1, 0};
    tbl[9]  = '{1'b0, 3'b010, 32'd510, 32'h0,        32'h00000000, 1'b1, 1, 0};
    tbl[10] = '{1'b0, 3'b011, 32'd0,   32'h0,        32'h00000000, 1'b1, 1, 0};
    tbl[11] = '{1'b1, 3'b001, 32'd12,  32'h5555ABCD, 32'h00000000, 1'b0, 4, 1};
    tbl[12] = '{1'b0, 3'b010, 32'd12,  32'h0,        32'hABCD0000, 1'b0, 2, 0};
    tbl[13] = '{1'b0, 3'b000, 32'd13,  32'h0,        32'hFFFFFFCD, 1'b0, 2, 0};
    tbl[14] = '{1'b1, 3'b000, 32'd511, 32'h000000A5, 32'h00000000, 1'b0, 4, 1};
    tbl[15] = '{1'b0, 3'b100, 32'd511, 32'h0,        32'h000000A5, 1'b0, 2, 0};
    tbl[16] = '{1'b0, 3'b000, 32'd512, 32'h0,        32'h00000000, 1'b1, 1, 0};
    tbl[17] = '{1'b1, 3'b010, 32'hFFFFFFFC, 32'h1,   32'h00000000, 1'b1, 1, 0};
    tbl[18] = '{1'b1, 3'b010, 32'd16,  32'hCAFEF00D, 32'h00000000, 1'b0, 3, 1};
    tbl[19] = '{1'b1, 3'b100, 32'd20,  32'hFFFFFFFF, 32'h00000000, 1'b1, 1, 0};

    repeat (3) @(posedge clk);
    #1;
    check32("rst.req_ready",  {31'd0, req_ready},  32'd1);
    check32("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    check32("rst.resp_rdata", resp_rdata,          32'd0);
    check32("rst.resp_err",   {31'd0, resp_err},   32'd0);
    check32("rst.mem_addr",   mem_addr,            32'd0);
    check32("rst.mem_wdata",  mem_wdata,           32'd0);
    check32("rst.mem_write",  {31'd0, mem_write},  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++)
      run_one($sformatf("tbl%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
              1'b1, tbl[i].rd, tbl[i].er, tbl[i].lat, tbl[i].nw);

    // Reset while the SW sits in WSETUP: no write, no response.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'd16; req_wdata = 32'h11223344;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    w0  = n_wr;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check32("rstw.mem_write",  {31'd0, mem_write},  32'd0);
    check32("rstw.resp_valid", {31'd0, resp_valid}, 32'd0);
    check32("rstw.req_ready",  {31'd0, req_ready},  32'd1);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (resp_valid || mem_write) seen = 1'b1;
    end
    check32("rstw.activity", {31'd0, seen}, 32'd0);
    check32("rstw.writes", 32'(n_wr), 32'(w0));
    do_req(1'b0, 3'b010, 32'd16, 32'd0, rd, er, lat, nw, wat, post);
    check32("rstw.reload", rd, 32'hCAFEF00D);

    // Back-to-back: valid held across LW @0 and LW @4.
    model(1'b0, 3'b010, 32'd0, 32'd0, e1, dummy_er, dummy_lat, dummy_nw);
    model(1'b0, 3'b010, 32'd4, 32'd0, e2, dummy_er, dummy_lat, dummy_nw);
    base = n_acc; t0 = -1; t1 = -1; p1 = -1; p2 = -1; r1 = 32'd0; r2 = 32'd0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'd0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (n_acc == base + 1 && t0 < 0) begin t0 = cyc; req_addr = 32'd4; end
      if (n_acc == base + 2 && t1 < 0) begin t1 = cyc; req_valid = 1'b0; end
      if (resp_valid) begin
        if (p1 < 0) begin p1 = cyc; r1 = resp_rdata; end
        else if (p2 < 0) begin p2 = cyc; r2 = resp_rdata; end
      end
    end
    req_valid = 1'b0;
    check32("b2b.accepts", 32'(n_acc - base), 32'd2);
    check32("b2b.first_lat", 32'(p1 - t0), 32'd1);
    check32("b2b.second_accept", 32'(t1 - p1), 32'd2);
    check32("b2b.spacing", 32'(p2 - p1), 32'd3);
    check32("b2b.rdata0", r1, e1);
    check32("b2b.rdata4", r2, e2);

    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        if (we) f3 = 3'($urandom_range(0, 2));
        else begin
          f3 = 3'($urandom_range(0, 4));
          if (f3 == 3'd3) f3 = 3'd5;
        end
      end
      case ($urandom_range(0, 9))
        0:       addr = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
        1:       addr = 32'($urandom_range(500, 520));
        default: addr = 32'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 2) != 0) addr = addr & ~32'((1 << f3[1:0]) - 1);
      run_one($sformatf("rnd%0d", n), we, f3, addr, $urandom, 1'b0, 32'd0, 1'b0, 0, 0);
    end

    nbytes = 0;
    for (int i = 0; i < 512; i++) if (ram[i] != ref_mem[i]) nbytes++;
    check32("ram_image.bad_bytes", 32'(nbytes), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit between the RV32E core's memory stage and the byte-addressable, big-endian data RAM (32-bit bus, combinational read, write on rising edge of its write strobe, no byte enables).
- Converts LB/LH/LW/LBU/LHU/SB/SH/SW requests into RAM accesses.
- Sub-word stores use read-modify-write.
- Performs sign/zero extension and flags misaligned, out-of-range and illegal accesses.

Parameters:
- MEM_BYTES, 512, RAM size in bytes; an access is out of range if addr + size > MEM_BYTES.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle; a request is accepted on a rising edge with req_valid && req_ready.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 code:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - stores: 000 SB, 001 SH, 010 SW.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; low bits used for SB/SH.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load result; 0 for stores and errors.
- resp_err  output  1  valid with resp_valid: misaligned, out-of-range or illegal funct3.
- mem_addr  output  32  RAM address, registered.
- mem_wdata  output  32  RAM write data, registered.
- mem_write  output  1  RAM write strobe, registered, one-cycle pulse.
- mem_rdata  input  32  RAM read data: byte at mem_addr sits in [31:24].

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_addr=0, mem_wdata=0, mem_write=0; state=IDLE.
- States: IDLE, RD, WSETUP, WPULSE, RESP.
- Acceptance: only in IDLE; req_ready = (state==IDLE). The accept edge latches funct3, we, addr and wdata.
- Error check at accept: any of the following sends IDLE -> RESP with resp_err=1 and no RAM access (mem_write stays 0):
  - LH/LHU/SH with addr[0]=1;
  - LW/SW with addr[1:0]!=0;
  - out of range (size 1/2/4);
  - illegal funct3.
- Load path: IDLE -> RD -> RESP.
  - RD drives mem_addr=addr; mem_rdata is captured at the end of RD.
  - Extraction (big-endian): byte = rdata[31:24], half = rdata[31:16], word = rdata.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - resp_valid is high 2 cycles after the accept edge.
- SW path: IDLE -> WSETUP -> WPULSE -> RESP.
  - mem_addr and mem_wdata are stable from WSETUP through RESP.
  - mem_write=1 only during WPULSE.
  - resp_valid is high 3 cycles after accept.
- SB/SH path: IDLE -> RD -> WSETUP -> WPULSE -> RESP.
  - RD captures the current word.
  - Merge: SB replaces [31:24] with wdata[7:0]; SH replaces [31:16] with wdata[15:0]; all other bits are preserved.
  - resp_valid is high 4 cycles after accept.
- RESP lasts exactly 1 cycle, then IDLE. resp_rdata and resp_err are valid only while resp_valid=1 and are cleared to 0 afterwards.
- A new request can be accepted in the cycle after RESP (back-to-back, no bubble beyond RESP).
- mem_write is never high in two consecutive cycles and never high outside WPULSE.
- rst at any state: next edge returns to IDLE, mem_write=0, no resp_valid.
  - Reset during RD/WSETUP: no write occurs.
  - Reset during WPULSE: the write edge has already occurred, so the RAM is updated, but no response is produced.
- Address arithmetic is 32-bit unsigned; addr + size overflow past 2^32 counts as out of range.

Test Plan:
- SW 0xDEADBEEF @ addr 8 -> exactly one mem_write pulse (cycle 2 after accept); RAM bytes 8..11 = DE AD BE EF; resp_valid at cycle 3, resp_err=0.
- After the above: LB @ 8 -> resp_rdata=0xFFFFFFDE; LBU @ 8 -> 0x000000DE; LH @ 10 -> 0xFFFFBEEF; each resp_valid 2 cycles after accept.
- SB wdata=0x00000012 @ 9 -> RMW; LW @ 8 then returns 0xDE12BEEF; resp_valid 4 cycles after accept; single mem_write pulse.
- LH @ 3, SW @ 6, LW @ 510 (MEM_BYTES=512), funct3=011 -> each: resp_valid the cycle after accept, resp_err=1, resp_rdata=0, mem_write never asserted.
- Assert rst during WSETUP of SW 0x11223344 @ 16 -> no mem_write pulse, no resp_valid, req_ready=1 next cycle; LW @ 16 returns the prior contents.
- Back-to-back: hold req_valid with LW @ 0 then LW @ 4 -> second accepted the cycle after the first RESP; two resp_valid pulses 3 cycles apart.
